wb_arbiter: RTL and testbench

//  Writeback arbiter directly upstream of the 32x32 register file write port.

---
 rtl/wb_arbiter.sv | 88 ++++++++
 tb/tb_wb_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter merging single-cycle ALU results with queued load/MUL results
// Ports:
//   CLK, RST                       clock (rising edge), asynchronous active-high reset
//   ALU_VALID, ALU_RD, ALU_DATA    ALU result; ALU_STALL (comb) asks the ALU to hold
//   MEM_VALID, MEM_RD, MEM_DATA    load/MUL result offer; MEM_READY (comb) = FIFO not full
//   WE, A3, WD3                    registered register-file write port (never WE with A3==0)
//   PEND_MASK                      only with WB_PENDMASK_EN: bit r set while a queued entry targets xr
// Optional feature macro: WB_PENDMASK_EN
module wb_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ALU_VALID,
    input  logic [4:0]  ALU_RD,
    input  logic [31:0] ALU_DATA,
    output logic        ALU_STALL,
    input  logic        MEM_VALID,
    input  logic [4:0]  MEM_RD,
    input  logic [31:0] MEM_DATA,
    output logic        MEM_READY,
`ifdef WB_PENDMASK_EN
    output logic [31:0] PEND_MASK,
`endif
    output logic        WE,
    output logic [4:0]  A3,
    output logic [31:0] WD3
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [4:0]    fifo_rd   [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic [WW-1:0] wait_cnt;
    logic          e, a, starve, pop, alu_win, push;

    assign e         = count != '0;
    assign a         = ALU_VALID && ALU_RD != 5'd0;
    // the queue has lost MAX_WAIT times in a row: it takes this slot regardless of the ALU
    assign starve    = e && wait_cnt == WW'(MAX_WAIT);
    assign alu_win   = a && !starve;
    assign pop       = e && (!a || starve);
    assign MEM_READY = count < CW'(DEPTH);
    assign ALU_STALL = a && starve;
    // rd==0 results are handshaken normally but never stored
    assign push      = MEM_VALID && MEM_READY && MEM_RD != 5'd0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            wait_cnt <= '0;
            WE       <= 1'b0;
            A3       <= 5'd0;
            WD3      <= 32'd0;
        end else begin
            wptr     <= wptr + AW'(push);
            rptr     <= rptr + AW'(pop);
            count    <= count + CW'(push) - CW'(pop);
            wait_cnt <= pop ? '0 : (alu_win && e) ? wait_cnt + WW'(1) : wait_cnt;
            WE       <= alu_win || pop;
            A3       <= alu_win ? ALU_RD : pop ? fifo_rd[rptr] : A3;
            WD3      <= alu_win ? ALU_DATA : pop ? fifo_data[rptr] : WD3;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_rd[wptr]   <= MEM_RD;
            fifo_data[wptr] <= MEM_DATA;
        end
    end

`ifdef WB_PENDMASK_EN
    // walk only the occupied slots, starting at the head
    always_comb begin
        PEND_MASK = 32'd0;
        for (int i = 0; i < DEPTH; i++)
            if (CW'(i) < count) PEND_MASK[fifo_rd[rptr + AW'(i)]] = 1'b1;
        PEND_MASK[0] = 1'b0;
    end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed bench with a queue-based reference model for wb_arbiter
module tb_wb_arbiter;
    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ALU_VALID = 1'b0;
    logic [4:0]  ALU_RD = 5'd0;
    logic [31:0] ALU_DATA = 32'd0;
    logic        ALU_STALL;
    logic        MEM_VALID = 1'b0;
    logic [4:0]  MEM_RD = 5'd0;
    logic [31:0] MEM_DATA = 32'd0;
    logic        MEM_READY;
    logic        WE;
    logic [4:0]  A3;
    logic [31:0] WD3;
`ifdef WB_PENDMASK_EN
    logic [31:0] PEND_MASK;
`endif

    int vectors = 0;
    int miscompares = 0;

    wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .RST(RST),
        .ALU_VALID(ALU_VALID), .ALU_RD(ALU_RD), .ALU_DATA(ALU_DATA), .ALU_STALL(ALU_STALL),
        .MEM_VALID(MEM_VALID), .MEM_RD(MEM_RD), .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY),
`ifdef WB_PENDMASK_EN
        .PEND_MASK(PEND_MASK),
`endif
        .WE(WE), .A3(A3), .WD3(WD3)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: a queue of {rd,data}, a loss counter and the expected write port
    logic [36:0] q[$];
    int          mwait;
    logic        exp_we;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd3;
    logic        m_e, m_a, m_starve, m_rdy;
    logic [31:0] m_mask;

    initial forever begin
        @(negedge CLK);
        if (RST) begin
            q.delete();
            mwait   = 0;
            exp_we  = 1'b0;
            exp_a3  = 5'd0;
            exp_wd3 = 32'd0;
        end
        m_e      = q.size() != 0;
        m_a      = ALU_VALID && ALU_RD != 5'd0;
        m_starve = m_e && mwait == MAX_WAIT;
        m_rdy    = q.size() < DEPTH;
        chk("we", 32'(WE), 32'(exp_we));
        chk("a3", 32'(A3), 32'(exp_a3));
        chk("wd3", WD3, exp_wd3);
        chk("mem_ready", 32'(MEM_READY), 32'(m_rdy));
        chk("alu_stall", 32'(ALU_STALL), 32'(m_a && m_starve));
`ifdef WB_PENDMASK_EN
        m_mask = 32'd0;
        foreach (q[i]) m_mask[q[i][36:32]] = 1'b1;
        chk("pend_mask", PEND_MASK, m_mask);
`endif
        if (!RST) begin
            if (m_a && !m_starve) begin
                exp_we  = 1'b1;
                exp_a3  = ALU_RD;
                exp_wd3 = ALU_DATA;
                if (m_e) mwait++;
            end else if (m_e) begin
                exp_we = 1'b1;
                {exp_a3, exp_wd3} = q.pop_front();
                mwait = 0;
            end else begin
                exp_we = 1'b0;
            end
            if (MEM_VALID && m_rdy && MEM_RD != 5'd0) q.push_back({MEM_RD, MEM_DATA});
        end
    end

    task automatic set_in(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                          input logic mv, input logic [4:0] mr, input logic [31:0] md);
        ALU_VALID = av; ALU_RD = ar; ALU_DATA = ad;
        MEM_VALID = mv; MEM_RD = mr; MEM_DATA = md;
        #1;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        // ALU only
        set_in(1, 5, 32'hDEADBEEF, 0, 0, 0);
        tick;
        chk("alu_we", 32'(WE), 1);
        chk("alu_a3", 32'(A3), 5);
        chk("alu_wd3", WD3, 32'hDEADBEEF);
        set_in(0, 0, 0, 0, 0, 0);
        tick;
        chk("idle_we", 32'(WE), 0);
        chk("idle_a3_hold", 32'(A3), 5);
        // x0 filter
        set_in(1, 0, 32'h1234, 1, 0, 32'h1234);
        chk("x0_stall", 32'(ALU_STALL), 0);
        chk("x0_ready", 32'(MEM_READY), 1);
        tick;
        chk("x0_we0", 32'(WE), 0);
        set_in(0, 0, 0, 0, 0, 0);
        tick;
        chk("x0_we1", 32'(WE), 0);
        // fill under continuous ALU traffic, then starvation
        for (int i = 1; i <= 4; i++) begin
            set_in(1, 5'(20 + i), 32'(100 + i), 1, 5'(i), 32'(200 + i));
            tick;
        end
        set_in(1, 25, 125, 0, 0, 0);
        chk("fill_ready", 32'(MEM_READY), 0);
        chk("starve_stall", 32'(ALU_STALL), 1);
        tick;
        chk("starve_a3", 32'(A3), 1);
        chk("starve_wd3", WD3, 201);
        tick;
        chk("held_alu_a3", 32'(A3), 25);
        set_in(0, 0, 0, 0, 0, 0);
        for (int j = 2; j <= 4; j++) begin
            tick;
            chk("fill_drain_a3", 32'(A3), 32'(j));
        end
        tick;
        chk("fill_empty_we", 32'(WE), 0);
        // drain order
        set_in(1, 26, 126, 1, 7, 307); tick;
        set_in(1, 27, 127, 1, 8, 308); tick;
        set_in(1, 28, 128, 1, 9, 309); tick;
        set_in(0, 0, 0, 0, 0, 0);
        for (int j = 7; j <= 9; j++) begin
            tick;
            chk("drain_we", 32'(WE), 1);
            chk("drain_a3", 32'(A3), 32'(j));
        end
        tick;
        chk("drain_end_we", 32'(WE), 0);
        // refill a full FIFO in the cycle after a forced pop
        for (int i = 11; i <= 14; i++) begin
            set_in(1, 30, 32'(i), 1, 5'(i), 32'(400 + i));
            tick;
        end
        set_in(1, 30, 130, 1, 10, 310);
        chk("full_ready", 32'(MEM_READY), 0);
        chk("full_stall", 32'(ALU_STALL), 1);
        tick;
        chk("full_pop_a3", 32'(A3), 11);
        chk("after_pop_ready", 32'(MEM_READY), 1);
        chk("after_pop_stall", 32'(ALU_STALL), 0);
        tick;
        chk("refill_alu_a3", 32'(A3), 30);
        chk("refull_ready", 32'(MEM_READY), 0);
        set_in(0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 4; j++) begin
            tick;
            chk("refill_drain_a3", 32'(A3), (j == 3) ? 32'd10 : 32'(12 + j));
        end
        chk("last_wd3", WD3, 310);
        tick;
        chk("refill_end_we", 32'(WE), 0);
`ifdef WB_PENDMASK_EN
        set_in(1, 29, 1, 1, 3, 33); tick;
        chk("mask_one", PEND_MASK, 32'h8);
        set_in(1, 29, 2, 1, 3, 34); tick;
        chk("mask_two", PEND_MASK, 32'h8);
        set_in(0, 0, 0, 0, 0, 0);
        tick;
        chk("mask_pop1", PEND_MASK, 32'h8);
        tick;
        chk("mask_pop2", PEND_MASK, 32'h0);
`endif
        // reset mid-burst with three entries queued
        for (int i = 15; i <= 17; i++) begin
            set_in(1, 31, 32'(i), 1, 5'(i), 32'(500 + i));
            tick;
        end
        chk("pre_reset_we", 32'(WE), 1);
        set_in(0, 0, 0, 0, 0, 0);
        RST = 1'b1;
        #1;
        chk("reset_we", 32'(WE), 0);
        chk("reset_a3", 32'(A3), 0);
        chk("reset_wd3", WD3, 0);
        tick;
        tick;
        RST = 1'b0;
        #1;
        chk("post_reset_ready", 32'(MEM_READY), 1);
        for (int j = 0; j < 3; j++) begin
            tick;
            chk("post_reset_we", 32'(WE), 0);
        end
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
